// File: rtl/mem_if_pkg.sv
// Shared types and constants for the data-memory responder.
// Combinational definitions only; no timing or flow control of its own.
// Imported by the responder FSM and its storage array.
package mem_if_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam logic [1:0] ALIGN_OK = 2'b00;

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte write enables and a combinational read.
// Latency: write commits at the clock edge, read is same-cycle.
// Backpressure: none; the owner sequences every access.
module dmem_array
    import mem_if_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one load/store at a time with WAIT_CYCLES wait states.
// Latency: accept at E0, access and rsp_valid at E0+WAIT_CYCLES+1.
// Backpressure: response held while rsp_ready=0; req_ready low until handshake.
module data_mem_responder
    import mem_if_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t            state;
    logic [3:0]        cnt;
    logic              lat_write;
    logic [31:0]       lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [STRB_W-1:0] lat_wstrb;

    logic              access;
    logic              err;
    logic              mem_we;
    logic [DATA_W-1:0] arr_rdata;

    // Out-of-range addresses alias into the array index, so err gates both paths.
    assign err    = (lat_addr[1:0] != ALIGN_OK) ||
                    ({2'b00, lat_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign access = (state == WAIT) && (cnt == 4'd0);
    assign mem_we = access && lat_write && !err;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk  (clk),
        .rst  (rst),
        .we   (mem_we),
        .addr (lat_addr[AW+1:2]),
        .wdata(lat_wdata),
        .wstrb(lat_wstrb),
        .rdata(arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            cnt       <= '0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wstrb <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        lat_write <= req_write;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_wstrb <= req_wstrb;
                        cnt       <= 4'(WAIT_CYCLES);
                        req_ready <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= err;
                        rsp_rdata <= (lat_write || err) ? '0 : arr_rdata;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed and randomized bench for data_mem_responder against a word-array model.
module tb_data_mem_responder;

    localparam int DEPTH = 256;
    localparam int WAITC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        z_req_valid, z_req_write, z_rsp_ready;
    logic [31:0] z_req_addr, z_req_wdata;
    logic [3:0]  z_req_wstrb;
    logic        z_req_ready, z_rsp_valid, z_rsp_err;
    logic [31:0] z_rsp_rdata;

    int checks = 0;
    int failures = 0;

    logic [31:0] model  [DEPTH];
    logic [31:0] zmodel [DEPTH];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_wstrb(z_req_wstrb),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic addr_faults(input logic [31:0] a);
        return (a % 4 != 0) || (a / 4 >= DEPTH);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    // One transaction on the WAIT_CYCLES=2 instance; starts and ends 1 time unit after an edge.
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int hold, output logic [31:0] rd_o);
        int          n;
        logic        experr;
        logic [31:0] exprd;
        experr = addr_faults(a);
        exprd  = '0;
        if (!experr) begin
            if (w) model[a / 4] = merge(model[a / 4], d, s);
            else   exprd = model[a / 4];
        end
        check("req_ready_idle", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        // Garbage on the request bus must not reach the latched copy.
        req_valid = 1'($urandom); req_write = 1'($urandom); req_addr = $urandom;
        req_wdata = $urandom; req_wstrb = 4'($urandom);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", 64'(n), 64'(WAITC + 1));
        check("rsp", {29'd0, req_ready, rsp_err, rsp_rdata}, {29'd0, 1'b0, experr, exprd});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold", {28'd0, rsp_valid, req_ready, rsp_err, rsp_rdata},
                  {28'd0, 1'b1, 1'b0, experr, exprd});
        end
        rd_o = rsp_rdata;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("back_idle", {62'd0, rsp_valid, req_ready}, 64'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        logic        seen;
        int          last_acc, accs, rsps;
        logic [31:0] q_rd[$];
        logic        q_er[$];
        logic        acc_now;
        logic [31:0] exp_rd;
        logic        exp_er;

        rst = 1'b0;
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0; rsp_ready = 0;
        z_req_valid = 0; z_req_write = 0; z_req_addr = 0; z_req_wdata = 0; z_req_wstrb = 0;
        z_rsp_ready = 0;
        for (int i = 0; i < DEPTH; i++) begin model[i] = '0; zmodel[i] = '0; end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        check("reset_state", {29'd0, req_ready, rsp_valid, rsp_err, rsp_rdata},
              {29'd0, 1'b1, 1'b0, 1'b0, 32'd0});

        // Full store then readback, then a single-lane merge.
        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd);
        check("load_deadbeef", {32'd0, rd}, {32'd0, 32'hDEADBEEF});
        txn(1'b1, 32'h10, 32'h000000AA, 4'h1, 0, rd);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd);
        check("load_deadbeaa", {32'd0, rd}, {32'd0, 32'hDEADBEAA});

        // Faulting accesses and a zero-strobe store.
        txn(1'b0, 32'h13, 32'h0, 4'h0, 0, rd);
        txn(1'b0, 32'h400, 32'h0, 4'h0, 0, rd);
        txn(1'b1, 32'h401, 32'h12345678, 4'hF, 0, rd);
        txn(1'b1, 32'h3FC, 32'h0BADF00D, 4'h0, 0, rd);
        txn(1'b0, 32'h3FC, 32'h0, 4'h0, 0, rd);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd);

        // Response back-pressure for 10 cycles.
        txn(1'b0, 32'h10, 32'h0, 4'h0, 10, rd);

        for (int t = 0; t < 40; t++) begin
            a = 32'($urandom_range(0, 299)) << 2;
            if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
            txn(1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 3)), rd);
        end

        // Reset while a store is in its wait states.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20;
        req_wdata = 32'hFFFFFFFF; req_wstrb = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_wait", {62'd0, rsp_valid, req_ready}, 64'd1);
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seen = seen | rsp_valid;
            @(posedge clk); #1;
        end
        check("rsp_after_rst", {63'd0, seen}, 64'd0);
        for (int i = 0; i < DEPTH; i++) begin model[i] = '0; zmodel[i] = '0; end
        txn(1'b0, 32'h20, 32'h0, 4'h0, 0, rd);
        check("load_after_rst", {32'd0, rd}, 64'd0);

        // Zero-wait instance, back-to-back alternating stores and loads.
        last_acc = -1; accs = 0; rsps = 0;
        z_rsp_ready = 1'b1; z_req_valid = 1'b1;
        z_req_write = 1'b1; z_req_addr = 32'($urandom_range(0, 15)) << 2;
        z_req_wdata = $urandom; z_req_wstrb = 4'hF;
        for (int cyc = 0; cyc < 45; cyc++) begin
            acc_now = z_req_ready;
            if (z_rsp_valid) begin
                check("z_rsp_expected", 64'(q_rd.size() != 0), 64'd1);
                if (q_rd.size() != 0) begin
                    exp_rd = q_rd.pop_front();
                    exp_er = q_er.pop_front();
                    check("z_rsp", {31'd0, z_rsp_err, z_rsp_rdata}, {31'd0, exp_er, exp_rd});
                end
                rsps++;
            end
            if (acc_now) begin
                if (last_acc >= 0) check("z_interval", 64'(cyc - last_acc), 64'd3);
                last_acc = cyc;
                accs++;
                if (z_req_write) begin
                    zmodel[z_req_addr / 4] = merge(zmodel[z_req_addr / 4], z_req_wdata, z_req_wstrb);
                    q_rd.push_back(32'd0);
                end else begin
                    q_rd.push_back(zmodel[z_req_addr / 4]);
                end
                q_er.push_back(1'b0);
            end
            @(posedge clk); #1;
            if (acc_now) begin
                if (z_req_write) begin
                    z_req_write = 1'b0;
                end else begin
                    z_req_write = 1'b1;
                    z_req_addr  = 32'($urandom_range(0, 15)) << 2;
                    z_req_wdata = $urandom;
                end
            end
        end
        z_req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (z_rsp_valid) begin
                if (q_rd.size() != 0) begin
                    exp_rd = q_rd.pop_front();
                    exp_er = q_er.pop_front();
                    check("z_rsp_drain", {31'd0, z_rsp_err, z_rsp_rdata}, {31'd0, exp_er, exp_rd});
                end
                rsps++;
            end
            @(posedge clk); #1;
        end
        check("z_accepts", 64'(accs), 64'd15);
        check("z_rsp_count", 64'(rsps), 64'(accs));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
